objects_draw_arbiter: RTL

Per-pixel arbiter that shares the single VGA RGB output between the background drawer, its border request, and NUM_LAYERS object drawers. It sits between the drawers and the VGA controller. Each pixel clock it picks the highest-priority non-transparent requester and registers its colour. It also records which sources overlapped during each frame, and raises a one-cycle pulse on the first overlap of a frame for game logic.

---
 rtl/draw_pkg.sv | 9 +
 rtl/objects_draw_arbiter_if.sv | 26 ++
 rtl/draw_priority_select.sv | 35 +++
 rtl/objects_draw_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the object draw arbiter.
package draw_pkg;
    typedef logic [7:0] rgb_t;

    localparam rgb_t TRANSPARENT_RGB    = 8'hFF;
    localparam int   DEFAULT_NUM_LAYERS = 4;

    typedef enum logic {IDLE, HIT} collision_state_t;
endpackage

// File: rtl/objects_draw_arbiter_if.sv
// Per-pixel drawer inputs and arbitrated outputs between the drawers and the VGA controller.
interface objects_draw_arbiter_if
    import draw_pkg::*;
#(
    parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS
);
    logic                          startOfFrame;
    logic [NUM_LAYERS:0]           layerEnable;
    logic [NUM_LAYERS-1:0]         drawReq;
    rgb_t [NUM_LAYERS-1:0]         drawRGB;
    logic                          boardersDrawReq;
    rgb_t                          BG_RGB;
    rgb_t                          RGBOut;
    logic                          collisionPulse;
    logic [NUM_LAYERS:0]           frameCollisionMask;

    modport master (
        output startOfFrame, layerEnable, drawReq, drawRGB, boardersDrawReq, BG_RGB,
        input  RGBOut, collisionPulse, frameCollisionMask
    );

    modport slave (
        input  startOfFrame, layerEnable, drawReq, drawRGB, boardersDrawReq, BG_RGB,
        output RGBOut, collisionPulse, frameCollisionMask
    );
endinterface

// File: rtl/draw_priority_select.sv
// Combinational pixel winner selection and overlap detection.
module draw_priority_select
    import draw_pkg::*;
#(
    parameter int   NUM_LAYERS = DEFAULT_NUM_LAYERS,
    parameter rgb_t BG_DEFAULT = 8'h00
) (
    input  logic [NUM_LAYERS-1:0] effReq,
    input  rgb_t [NUM_LAYERS-1:0] drawRGB,
    input  logic                  effBorder,
    input  rgb_t                  BG_RGB,
    input  logic                  bgEnable,
    output rgb_t                  selRGB,
    output logic                  overlap
);
    localparam int CW = $clog2(NUM_LAYERS + 2);

    logic [CW-1:0] n_src;

    // Border and plain background share BG_RGB, so the border needs no colour path of its own.
    always_comb begin
        selRGB = bgEnable ? BG_RGB : BG_DEFAULT;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (effReq[i]) selRGB = drawRGB[i];
        end
    end

    always_comb begin
        n_src = {{(CW-1){1'b0}}, effBorder};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            n_src = n_src + {{(CW-1){1'b0}}, effReq[i]};
        end
        overlap = (n_src >= CW'(2));
    end
endmodule

// File: rtl/objects_draw_arbiter.sv
// Shares the VGA RGB output between background, border and object drawers; tracks per-frame overlaps.
//   state | meaning
//   IDLE  | no overlap seen yet in the current frame
//   HIT   | overlap already reported this frame, pulse suppressed
module objects_draw_arbiter
    import draw_pkg::*;
#(
    parameter int   NUM_LAYERS  = DEFAULT_NUM_LAYERS,
    parameter rgb_t TRANSPARENT = TRANSPARENT_RGB,
    parameter rgb_t BG_DEFAULT  = 8'h00
) (
    input logic                   clk,
    input logic                   resetN,
    objects_draw_arbiter_if.slave bus
);
    logic [NUM_LAYERS-1:0] eff_req;
    logic                  eff_border;
    logic [NUM_LAYERS:0]   src;
    rgb_t                  sel_rgb;
    logic                  overlap;

    rgb_t                  rgb_d, rgb_q;
    logic                  pulse_d, pulse_q;
    logic [NUM_LAYERS:0]   run_mask_d, run_mask_q;
    logic [NUM_LAYERS:0]   frame_mask_d, frame_mask_q;
    collision_state_t      state_d, state_q;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_req[i] = bus.drawReq[i] & bus.layerEnable[i] & (bus.drawRGB[i] != TRANSPARENT);
        end
    end

    assign eff_border = bus.boardersDrawReq & bus.layerEnable[NUM_LAYERS];
    assign src        = {eff_border, eff_req};

    draw_priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .BG_DEFAULT (BG_DEFAULT)
    ) u_select (
        .effReq    (eff_req),
        .drawRGB   (bus.drawRGB),
        .effBorder (eff_border),
        .BG_RGB    (bus.BG_RGB),
        .bgEnable  (bus.layerEnable[NUM_LAYERS]),
        .selRGB    (sel_rgb),
        .overlap   (overlap)
    );

    // The startOfFrame pixel already belongs to the new frame, so its overlap seeds the fresh mask.
    always_comb begin
        rgb_d        = sel_rgb;
        pulse_d      = 1'b0;
        state_d      = state_q;
        run_mask_d   = run_mask_q;
        frame_mask_d = frame_mask_q;
        if (bus.startOfFrame) begin
            frame_mask_d = run_mask_q;
            run_mask_d   = overlap ? src : '0;
            state_d      = overlap ? HIT : IDLE;
            pulse_d      = overlap;
        end else if (overlap) begin
            run_mask_d = run_mask_q | src;
            if (state_q == IDLE) begin
                state_d = HIT;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q        <= '0;
            pulse_q      <= 1'b0;
            run_mask_q   <= '0;
            frame_mask_q <= '0;
            state_q      <= IDLE;
        end else begin
            rgb_q        <= rgb_d;
            pulse_q      <= pulse_d;
            run_mask_q   <= run_mask_d;
            frame_mask_q <= frame_mask_d;
            state_q      <= state_d;
        end
    end

    assign bus.RGBOut             = rgb_q;
    assign bus.collisionPulse     = pulse_q;
    assign bus.frameCollisionMask = frame_mask_q;
endmodule
